mul_iter_unit: RTL
==================

# mul_iter_unit

Iterative shift-add multiplier sitting beside the ALU in the execute path of the processor. It consumes the two register-file read ports (RD1, RD2) and drives the register-file write port (WD3, A3, WE3) with the low WIDTH bits of the product. It provides MUL without a combinational 32x32 array, at the cost of a multi-cycle BUSY window that the control unit must stall on.

## Interface
- WIDTH, 32, operand and result width in bits.
- CNT_W, 5, iteration-counter width; must satisfy 2^CNT_W >= WIDTH.

- CLK  input  1  clock; all state updates on the rising edge.
- RESET_N  input  1  reset, asynchronous and active-low.
- START  input  1  request a multiply; sampled only in IDLE.
- RD1  input  WIDTH  multiplicand, from register-file port 1.
- RD2  input  WIDTH  multiplier, from register-file port 2.
- RDEST  input  4  destination register index, captured with START.
- BUSY  output  1  high in RUN and WB; the control unit stalls issue while it is high.
- DONE  output  1  one-cycle completion pulse, identical to WE3.
- WE3  output  1  register-file write enable.
- A3  output  4  register-file write address (the captured RDEST).
- WD3  output  WIDTH  register-file write data (the product).

## Operation
- State machine states:
  - IDLE: waits for START.
  - RUN: performs one iteration per cycle.
  - WB: drives one write-back cycle.
- Internal registers: mcand, mplier, acc (each WIDTH bits); cnt (CNT_W bits); dest (4 bits).
- IDLE with START=1 at an edge:
  - load mcand=RD1, mplier=RD2, acc=0, cnt=0, dest=RDEST.
  - move to RUN.
- IDLE with START=0: hold all registers.
- RUN, at each edge:
  - if mplier[0]=1, acc = acc + mcand; the sum is truncated to WIDTH bits and the carry is discarded.
  - mcand shifts left by 1, zero-fill.
  - mplier shifts right by 1, logical.
  - cnt increments by 1.
  - the state moves to WB when cnt was WIDTH-1 before this edge.
- WB: the next edge returns the state to IDLE. The register file performs its write on that same edge.
- START is ignored in RUN and WB; no queueing.
- Result is the product modulo 2^WIDTH, identical for signed and unsigned operands.
- Output decode:
  - WE3 = DONE = (state==WB).
  - BUSY = (state!=IDLE).
  - A3 = dest.
  - WD3 = acc.
- RESET_N low at any time, including mid-RUN or during WB:
  - the state goes to IDLE immediately and all registers clear.
  - any pending write is abandoned; WE3 never asserts for that operation.
- Reset value of every output is 0: BUSY, DONE, WE3, A3, WD3.

## Timing
- Take START accepted at edge k. Then:
  - BUSY rises after edge k.
  - RUN occupies edges k+1 to k+WIDTH.
  - WB (WE3=DONE=1) is the cycle between edge k+WIDTH and edge k+WIDTH+1.
  - the register-file write happens at edge k+WIDTH+1.
- BUSY falls after edge k+WIDTH+1. The earliest next accepted START is edge k+WIDTH+2.
- Minimum issue interval: WIDTH+2 cycles.
- WE3 is high for exactly one cycle per accepted START.
- A3 and WD3 are stable throughout that cycle.
- RD1, RD2 and RDEST are only required to be valid at the accepting edge.

## Configuration
- MUL_EARLY_TERM_EN defined:
  - in RUN, the state also moves to WB when the shifted mplier value being written is zero.
  - RUN length = max(1, index of the highest set bit of RD2 + 1) cycles.
  - RD2=0 gives WB after edge k+1.
  - the result is unchanged.
- MUL_EARLY_TERM_EN undefined: RUN is always exactly WIDTH cycles, giving fixed latency.

## Test plan
- Reset: hold RESET_N=0 for 3 cycles with random inputs -> BUSY=DONE=WE3=0, A3=0, WD3=0.
- RD1=3, RD2=5, RDEST=4, START at edge k, macro undefined -> single WE3 pulse between edges k+32 and k+33 with WD3=15 and A3=4; BUSY low after edge k+33.
- RD1=RD2=0xFFFF_FFFF -> WD3=0x0000_0001; RD1=0x0001_0000 and RD2=0x0001_0000 -> WD3=0x0000_0000.
- START held high for 40 cycles, with RD1=7 and RD2=6 at edge k and other operand values on later cycles -> exactly one WE3 before edge k+34 with WD3=42; the next operation is accepted at edge k+34.
- RESET_N pulsed low at edge k+10 of a running operation -> BUSY=0 immediately, no WE3 at any later cycle, next START accepted normally.
- MUL_EARLY_TERM_EN defined:
  - RD2=0 -> WE3 between edges k+1 and k+2, WD3=0.
  - RD1=9, RD2=0x10 -> 5 RUN cycles, WE3 between edges k+5 and k+6, WD3=144.
  - RD2=0x8000_0000 -> full 32-cycle latency.

Source files
------------

// File: rtl/mul_iter_unit_if.sv
// Register-file facing bundle of the iterative multiplier.
// The master side issues operands; the slave side is the multiplier.
interface mul_iter_unit_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic [3:0]       RDEST;
    logic             BUSY;
    logic             DONE;
    logic             WE3;
    logic [3:0]       A3;
    logic [WIDTH-1:0] WD3;

    modport master (
        output START, RD1, RD2, RDEST,
        input  BUSY, DONE, WE3, A3, WD3
    );

    modport slave (
        input  START, RD1, RD2, RDEST,
        output BUSY, DONE, WE3, A3, WD3
    );
endinterface

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier: IDLE -> RUN (one bit per cycle) -> WB.
// Optional macro MUL_EARLY_TERM_EN ends RUN once the multiplier is exhausted.
module mul_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input logic            CLK,
    input logic            RESET_N,
    mul_iter_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       dest_q, dest_d;

    // State and datapath registers; reset abandons any pending write.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            dest_q   <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dest_q   <= dest_d;
        end
    end

    // Next-state and datapath step: load on START, one shift-add per RUN cycle.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dest_d   = dest_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    mcand_d  = bus.RD1;
                    mplier_d = bus.RD2;
                    acc_d    = '0;
                    cnt_d    = '0;
                    dest_d   = bus.RDEST;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
`ifdef MUL_EARLY_TERM_EN
                if (cnt_q == CNT_LAST || mplier_d == '0) begin
                    state_d = S_WB;
                end
`else
                if (cnt_q == CNT_LAST) begin
                    state_d = S_WB;
                end
`endif
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode straight from the registered state.
    always_comb begin
        bus.BUSY = (state_q != S_IDLE);
        bus.WE3  = (state_q == S_WB);
        bus.DONE = (state_q == S_WB);
        bus.A3   = dest_q;
        bus.WD3  = acc_q;
    end
endmodule
